// File: rtl/snn_rate_encoder_pkg.sv
// Shared encodings for the rate encoder: FSM states, encode modes and the
// 16-bit Galois LFSR used by the Bernoulli mode.
package snn_rate_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_REST = 2'd2
    } state_t;

    localparam int MODE_PHASE = 0;
    localparam int MODE_LFSR  = 1;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11, right-shifting

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // An all-zero Galois LFSR locks up, so a zero seed is replaced by 1.
    function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] base, input int idx);
        logic [LFSR_W-1:0] s;
        s = base ^ LFSR_W'(idx + 1);
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

endpackage

// File: rtl/snn_rate_encoder_if.sv
// Sample-in / spike-out bundle of the rate encoder; master is the stimulus side.
interface snn_rate_encoder_if #(
    parameter int NUM_CHANNELS    = 1,
    parameter int INTENSITY_WIDTH = 8
);
    logic                                      in_valid;
    logic                                      in_ready;
    logic [NUM_CHANNELS*INTENSITY_WIDTH-1:0]   in_intensity;
    logic [NUM_CHANNELS-1:0]                   spike_out;
    logic                                      busy;
    logic                                      window_done;

    modport master (
        output in_valid, in_intensity,
        input  in_ready, spike_out, busy, window_done
    );

    modport slave (
        input  in_valid, in_intensity,
        output in_ready, spike_out, busy, window_done
    );
endinterface

// File: rtl/snn_rate_encoder_spike_gen_channel.sv
// One encoder channel: latches its intensity on load and produces one
// registered spike decision per step, by phase accumulation or LFSR compare.
module snn_spike_gen_channel
    import snn_rate_encoder_pkg::*;
#(
    parameter int                W    = 8,
    parameter int                MODE = MODE_PHASE,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [W-1:0] i_intensity,
    output logic         o_spike
);
    logic [W-1:0] r_int;
    logic         r_spike;
    logic         w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int   <= '0;
            r_spike <= 1'b0;
        end else begin
            if (i_load) r_int <= i_intensity;
            r_spike <= i_step & w_hit;
        end
    end

    generate
        if (MODE == MODE_LFSR) begin : g_lfsr
            logic [LFSR_W-1:0] r_lfsr;

            // The sequence free-runs across windows; only reset reloads the seed.
            always_ff @(posedge clk) begin
                if (rst)         r_lfsr <= SEED;
                else if (i_step) r_lfsr <= lfsr_next(r_lfsr);
            end

            assign w_hit = (W'(r_lfsr) < r_int);
        end else begin : g_phase
            logic [W-1:0] r_acc;
            logic [W:0]   w_sum;

            assign w_sum = {1'b0, r_acc} + {1'b0, r_int};
            assign w_hit = w_sum[W];

            always_ff @(posedge clk) begin
                if (rst || i_load) r_acc <= '0;
                else if (i_step)   r_acc <= w_sum[W-1:0];
            end
        end
    endgenerate

    assign o_spike = r_spike;

endmodule

// File: rtl/snn_rate_encoder.sv
// Rate encoder top: accepts an intensity vector, runs a WINDOW_CYCLES spike
// window on every channel, then an optional silent rest before the next sample.
module snn_rate_encoder
    import snn_rate_encoder_pkg::*;
#(
    parameter int          NUM_CHANNELS    = 1,
    parameter int          INTENSITY_WIDTH = 8,
    parameter int          WINDOW_CYCLES   = 16,
    parameter int          REST_CYCLES     = 0,
    parameter int          ENCODE_MODE     = MODE_PHASE,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input logic               clk,
    input logic               rst,
    snn_rate_encoder_if.slave bus
);
    localparam int W       = INTENSITY_WIDTH;
    localparam int CNT_MAX = (WINDOW_CYCLES > REST_CYCLES) ? WINDOW_CYCLES : REST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_REST = CNT_W'((REST_CYCLES > 0) ? REST_CYCLES - 1 : 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_window_done;
    logic               w_accept;
    logic               w_step;
    logic [NUM_CHANNELS-1:0] w_spike;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_step   = (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_window_done <= 1'b0;
        end else begin
            r_window_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == LAST_SLOT) begin
                        r_window_done <= 1'b1;
                        r_cnt         <= '0;
                        if (REST_CYCLES > 0) r_state <= ST_REST;
                        else                 r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_REST: begin
                    if (r_cnt == LAST_REST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            snn_spike_gen_channel #(
                .W    (W),
                .MODE (ENCODE_MODE),
                .SEED (lfsr_seed(LFSR_SEED, gi))
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .i_load      (w_accept),
                .i_step      (w_step),
                .i_intensity (bus.in_intensity[gi*W +: W]),
                .o_spike     (w_spike[gi])
            );
        end
    endgenerate

    assign bus.spike_out   = w_spike;
    assign bus.window_done = r_window_done;
    assign bus.in_ready    = (r_state == ST_IDLE);
    assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_snn_rate_encoder.sv
// Bench for snn_rate_encoder: three instances (phase/no rest, phase/rest 4,
// LFSR/no rest) checked slot by slot against a closed-form reference model.
module tb_snn_rate_encoder;
    localparam int NC = 3;
    localparam int W  = 8;
    localparam int T  = 16;

    typedef struct packed {
        logic [NC-1:0] spk;
        logic          wd;
        logic          rdy;
        logic          busy;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    int   checks = 0;
    int   errors = 0;

    logic [NC-1:0] stream[$];
    logic [15:0]   m_lfsr[NC];
    logic [15:0]   m_mask;

    snn_rate_encoder_if #(.NUM_CHANNELS(NC), .INTENSITY_WIDTH(W)) b0 ();
    snn_rate_encoder_if #(.NUM_CHANNELS(NC), .INTENSITY_WIDTH(W)) b1 ();
    snn_rate_encoder_if #(.NUM_CHANNELS(NC), .INTENSITY_WIDTH(W)) b2 ();

    snn_rate_encoder #(.NUM_CHANNELS(NC), .INTENSITY_WIDTH(W), .WINDOW_CYCLES(T),
                       .REST_CYCLES(0), .ENCODE_MODE(0), .LFSR_SEED(16'hACE1))
        dut0 (.clk(clk), .rst(rst0), .bus(b0));
    snn_rate_encoder #(.NUM_CHANNELS(NC), .INTENSITY_WIDTH(W), .WINDOW_CYCLES(T),
                       .REST_CYCLES(4), .ENCODE_MODE(0), .LFSR_SEED(16'hACE1))
        dut1 (.clk(clk), .rst(rst1), .bus(b1));
    snn_rate_encoder #(.NUM_CHANNELS(NC), .INTENSITY_WIDTH(W), .WINDOW_CYCLES(T),
                       .REST_CYCLES(0), .ENCODE_MODE(1), .LFSR_SEED(16'hACE1))
        dut2 (.clk(clk), .rst(rst2), .bus(b2));

    task automatic drive(input int sel, input logic v, input logic [NC*W-1:0] d);
        case (sel)
            0:       begin b0.in_valid = v; b0.in_intensity = d; end
            1:       begin b1.in_valid = v; b1.in_intensity = d; end
            default: begin b2.in_valid = v; b2.in_intensity = d; end
        endcase
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        case (sel)
            0:       o = '{b0.spike_out, b0.window_done, b0.in_ready, b0.busy};
            1:       o = '{b1.spike_out, b1.window_done, b1.in_ready, b1.busy};
            default: o = '{b2.spike_out, b2.window_done, b2.in_ready, b2.busy};
        endcase
        return o;
    endfunction

    // Phase mode: slot k spikes when floor(k*I/2^W) steps up, giving floor(I*T/2^W) per window.
    function automatic logic [NC-1:0] m0_slot(input logic [NC*W-1:0] vec, input int k);
        logic [NC-1:0] s;
        for (int ch = 0; ch < NC; ch++) begin
            int iv;
            iv = int'(vec[ch*W +: W]);
            s[ch] = ((k * iv) >> W) != (((k - 1) * iv) >> W);
        end
        return s;
    endfunction

    task automatic m1_reset();
        m_mask = 16'h0;
        foreach (m_mask[b]) ;
        // Right-shifting Galois form: tap exponent t feeds bit t-1.
        m_mask = (16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10);
        for (int ch = 0; ch < NC; ch++) begin
            m_lfsr[ch] = 16'hACE1 ^ 16'(ch + 1);
            if (m_lfsr[ch] == 16'h0) m_lfsr[ch] = 16'h1;
        end
    endtask

    task automatic m1_slot(input logic [NC*W-1:0] vec, output logic [NC-1:0] s);
        for (int ch = 0; ch < NC; ch++) begin
            logic [W-1:0] rnd;
            rnd   = m_lfsr[ch][W-1:0];
            s[ch] = (rnd < vec[ch*W +: W]);
            if (m_lfsr[ch][0]) m_lfsr[ch] = (m_lfsr[ch] >> 1) ^ m_mask;
            else               m_lfsr[ch] = m_lfsr[ch] >> 1;
        end
    endtask

    // Starts at a negedge with the DUT idle; ends on the sample after the last busy cycle.
    task automatic run_window(input int sel, input logic [NC*W-1:0] vec, input int rest,
                              input bit keep, output int cnt[NC]);
        obs_t o, e;
        logic [NC-1:0] m;
        bit last;
        cnt = '{0, 0, 0};
        drive(sel, 1'b1, vec);
        @(negedge clk);
        o = sample(sel);
        e = '{3'b000, 1'b0, 1'b0, 1'b1};
        checks++;
        if (o !== e) begin errors++; $display("FAIL accept dut%0d: got %b want %b", sel, o, e); end
        if (!keep) drive(sel, 1'b0, vec);
        for (int k = 1; k <= T; k++) begin
            @(negedge clk);
            o = sample(sel);
            if (sel == 2) m1_slot(vec, m);
            else          m = m0_slot(vec, k);
            last = (k == T) && (rest == 0);
            e = '{m, (k == T), last, !last};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL slot dut%0d k=%0d: got %b want %b (spk,wd,rdy,busy)", sel, k, o, e);
            end
            for (int ch = 0; ch < NC; ch++) cnt[ch] += int'(o.spk[ch]);
            stream.push_back(o.spk);
        end
        for (int r = 1; r <= rest; r++) begin
            @(negedge clk);
            o = sample(sel);
            e = '{3'b000, 1'b0, (r == rest), (r != rest)};
            checks++;
            if (o !== e) begin errors++; $display("FAIL rest dut%0d r=%0d: got %b want %b", sel, r, o, e); end
        end
        if (!keep) begin
            @(negedge clk);
            o = sample(sel);
            e = '{3'b000, 1'b0, 1'b1, 1'b0};
            checks++;
            if (o !== e) begin errors++; $display("FAIL post-window dut%0d: got %b want %b", sel, o, e); end
        end
    endtask

    task automatic test_reset();
        obs_t o, e;
        int bad;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        e = '{3'b000, 1'b0, 1'b1, 1'b0};
        for (int s = 0; s < 3; s++) begin
            o = sample(s);
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset dut%0d: got %b want %b", s, o, e); end
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) if (sample(s) !== e) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d bad samples want 0", bad); end
    endtask

    task automatic test_mode0_counts();
        int cnt[NC];
        logic [NC*W-1:0] vec;
        run_window(0, {8'd255, 8'd128, 8'd0}, 0, 1'b0, cnt);
        checks++;
        if (cnt[0] != 0 || cnt[1] != 8 || cnt[2] != 15) begin
            errors++;
            $display("FAIL mode0_counts: got %0d/%0d/%0d want 0/8/15", cnt[0], cnt[1], cnt[2]);
        end
        repeat (4) begin
            vec = NC*W'($urandom);
            run_window(0, vec, 0, 1'b0, cnt);
            for (int ch = 0; ch < NC; ch++) begin
                int want;
                want = (int'(vec[ch*W +: W]) * T) >> W;
                checks++;
                if (cnt[ch] != want) begin
                    errors++;
                    $display("FAIL mode0_rand ch%0d I=%0d: got %0d want %0d", ch, vec[ch*W +: W], cnt[ch], want);
                end
            end
        end
    endtask

    task automatic test_rest();
        int cnt[NC];
        int n, wds;
        obs_t o, e;
        logic [NC*W-1:0] vec;
        vec = {8'd17, 8'd64, 8'd200};
        run_window(1, vec, 4, 1'b1, cnt);
        for (int ch = 0; ch < NC; ch++) begin
            checks++;
            if (cnt[ch] != ((int'(vec[ch*W +: W]) * T) >> W)) begin
                errors++; $display("FAIL rest_counts ch%0d: got %0d", ch, cnt[ch]);
            end
        end
        // in_valid never dropped: the next acceptance lands on the first idle edge.
        @(negedge clk);
        o = sample(1);
        e = '{3'b000, 1'b0, 1'b0, 1'b1};
        checks++;
        if (o !== e) begin errors++; $display("FAIL rest_reaccept: got %b want %b", o, e); end
        drive(1, 1'b0, vec);
        n = 0; wds = 0;
        do begin
            @(negedge clk);
            o = sample(1);
            wds += int'(o.wd);
            n++;
        end while (o.rdy !== 1'b1 && n < 100);
        checks++;
        if (o.rdy !== 1'b1 || n != T + 4 || wds != 1) begin
            errors++;
            $display("FAIL rest_drain: got %0d cycles %0d pulses want %0d cycles 1 pulse", n, wds, T + 4);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        int cnt[3];
        int p;
        logic [NC*W-1:0] vec;
        vec = {8'd64, 8'd64, 8'd64};
        cnt = '{0, 0, 0};
        drive(0, 1'b1, vec);
        for (int c = 0; c < 3 * (T + 1); c++) begin
            @(negedge clk);
            o = sample(0);
            p = c % (T + 1);
            if (p == 0) e = '{3'b000, 1'b0, 1'b0, 1'b1};
            else        e = '{m0_slot(vec, p), (p == T), (p == T), (p != T)};
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b c=%0d: got %b want %b", c, o, e); end
            cnt[c / (T + 1)] += int'(o.spk[1]);
            if (c == 3 * (T + 1) - 1) drive(0, 1'b0, vec);
        end
        for (int wi = 0; wi < 3; wi++) begin
            checks++;
            if (cnt[wi] != 4) begin errors++; $display("FAIL b2b_count win%0d: got %0d want 4", wi, cnt[wi]); end
        end
        @(negedge clk);
        o = sample(0);
        e = '{3'b000, 1'b0, 1'b1, 1'b0};
        checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_stop: got %b want %b", o, e); end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        int cnt[NC];
        int bad;
        logic [NC*W-1:0] vec;
        vec = {8'd255, 8'd255, 8'd255};
        drive(0, 1'b1, vec);
        @(negedge clk);
        drive(0, 1'b0, vec);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            o = sample(0);
            checks++;
            if (o.spk !== m0_slot(vec, k)) begin
                errors++; $display("FAIL mid_slot k=%0d: got %b want %b", k, o.spk, m0_slot(vec, k));
            end
        end
        rst0 = 1'b1;
        @(negedge clk);
        o = sample(0);
        e = '{3'b000, 1'b0, 1'b1, 1'b0};
        checks++;
        if (o !== e) begin errors++; $display("FAIL mid_reset: got %b want %b", o, e); end
        rst0 = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (sample(0) !== e) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_quiet: got %0d bad samples want 0", bad); end
        run_window(0, vec, 0, 1'b0, cnt);
        checks++;
        if (cnt[0] != 15 || cnt[1] != 15 || cnt[2] != 15) begin
            errors++; $display("FAIL mid_refill: got %0d/%0d/%0d want 15", cnt[0], cnt[1], cnt[2]);
        end
    endtask

    task automatic mode1_run(output int tot[NC], output logic [NC-1:0] rec[$]);
        int cnt[NC];
        @(negedge clk); rst2 = 1'b1;
        @(negedge clk); rst2 = 1'b0;
        m1_reset();
        stream.delete();
        tot = '{0, 0, 0};
        for (int wi = 0; wi < 64; wi++) begin
            run_window(2, {8'd128, 8'd255, 8'd0}, 0, 1'b0, cnt);
            for (int ch = 0; ch < NC; ch++) tot[ch] += cnt[ch];
        end
        rec = stream;
    endtask

    task automatic test_mode1();
        int tot_a[NC], tot_b[NC];
        logic [NC-1:0] rec_a[$], rec_b[$];
        int diff;
        mode1_run(tot_a, rec_a);
        checks++;
        if (tot_a[0] != 0) begin errors++; $display("FAIL mode1_zero: got %0d want 0", tot_a[0]); end
        checks++;
        if (tot_a[1] < 864) begin errors++; $display("FAIL mode1_full: got %0d want >=864", tot_a[1]); end
        checks++;
        if (tot_a[2] < 350 || tot_a[2] > 680) begin
            errors++; $display("FAIL mode1_half: got %0d want 350..680", tot_a[2]);
        end
        mode1_run(tot_b, rec_b);
        diff = 0;
        if (rec_a.size() != rec_b.size()) diff = 1;
        else foreach (rec_a[i]) if (rec_a[i] !== rec_b[i]) diff++;
        checks++;
        if (diff != 0 || rec_a.size() != 64 * T) begin
            errors++; $display("FAIL mode1_repeat: got %0d differing slots of %0d want 0 of %0d", diff, rec_a.size(), 64 * T);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode0_counts();
        test_rest();
        test_back_to_back();
        test_reset_mid();
        test_mode1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
